// File: rtl/ttl_decoder_seq_pkg.sv
// rtl/ttl_decoder_seq_pkg.sv - shared state encoding and widths for the sequenced TTL decoder
package ttl_decoder_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam int CNT_W = 8;
  localparam int DIV_W = 16;

endpackage

// File: rtl/ttl_decoder_seq_div.sv
// rtl/ttl_decoder_seq_div.sv - scan-step prescaler: tick_o high on the last cycle of each SCAN_DIV period
module ttl_decoder_seq_div
  import ttl_decoder_seq_pkg::*;
#(
  parameter int SCAN_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [DIV_W-1:0] TC = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ttl_decoder_seq.sv
// rtl/ttl_decoder_seq.sv - registered active-low decoder with one-shot strobe and optional scan mode
// Scan mode (SCAN state, prescaler, index) is built only when TTL_DECODER_SEQ_SCAN_EN is defined.
module ttl_decoder_seq
  import ttl_decoder_seq_pkg::*;
#(
  parameter int WIDTH_OUT = 8,
  parameter int WIDTH_IN  = $clog2(WIDTH_OUT),
  parameter int PULSE_LEN = 1,
  parameter int SCAN_DIV  = 4
) (
  input  logic                 Clk,
  input  logic                 Clear_bar,
  input  logic                 Enable1_bar,
  input  logic                 Enable2_bar,
  input  logic                 Enable3,
  input  logic [WIDTH_IN-1:0]  A,
  input  logic                 Strobe,
  input  logic                 Scan,
  output logic [WIDTH_OUT-1:0] Y,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err
);

  localparam logic [WIDTH_OUT-1:0] ONE      = WIDTH_OUT'(1);
  localparam logic [WIDTH_IN:0]    WOUT_EXT = (WIDTH_IN + 1)'(WIDTH_OUT);
  localparam logic [CNT_W-1:0]     P_LAST   = CNT_W'(PULSE_LEN - 1);

  state_e                 state_q, state_d;
  logic [WIDTH_IN-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH_OUT-1:0]   y_q, y_d;
  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                   en, in_range;

  assign en       = ~Enable1_bar & ~Enable2_bar & Enable3;
  assign in_range = ({1'b0, A} < WOUT_EXT);

`ifdef TTL_DECODER_SEQ_SCAN_EN
  localparam logic [WIDTH_IN-1:0] IDX_LAST = WIDTH_IN'(WIDTH_OUT - 1);

  logic [WIDTH_IN-1:0] idx_q, idx_d;
  logic                scan_tick;

  // Prescaler runs only while scanning so every step starts a full period.
  ttl_decoder_seq_div #(.SCAN_DIV(SCAN_DIV)) u_div (
    .clk_i  (Clk),
    .rst_ni (Clear_bar),
    .clr_i  (state_q != SCAN),
    .tick_o (scan_tick)
  );
`else
  logic unused_scan;
  assign unused_scan = Scan;
`endif

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef TTL_DECODER_SEQ_SCAN_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef TTL_DECODER_SEQ_SCAN_EN
      idx_q   <= idx_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en && Strobe) begin
          if (in_range) state_d = ACTIVE;
        end
`ifdef TTL_DECODER_SEQ_SCAN_EN
        else if (en && Scan) begin
          state_d = SCAN;
        end
`endif
      end
      ACTIVE: begin
        if (!en || (cnt_q == P_LAST)) state_d = IDLE;
      end
`ifdef TTL_DECODER_SEQ_SCAN_EN
      SCAN: begin
        if (!en || !Scan) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Every exit path drives Y all-ones, so no transition can show two LOW bits.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    y_d    = '1;
    busy_d = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
`ifdef TTL_DECODER_SEQ_SCAN_EN
    idx_d  = idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (en && Strobe) begin
          if (in_range) begin
            addr_d = A;
            cnt_d  = '0;
            y_d    = ~(ONE << A);
            busy_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
`ifdef TTL_DECODER_SEQ_SCAN_EN
        else if (en && Scan) begin
          idx_d  = '0;
          y_d    = ~ONE;
          busy_d = 1'b1;
        end
`endif
      end
      ACTIVE: begin
        if (!en) begin
          cnt_d  = '0;
        end else if (cnt_q == P_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          y_d    = ~(ONE << addr_q);
          busy_d = 1'b1;
        end
      end
`ifdef TTL_DECODER_SEQ_SCAN_EN
      SCAN: begin
        if (!en || !Scan) begin
          idx_d = '0;
        end else begin
          if (scan_tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + WIDTH_IN'(1);
          y_d    = ~(ONE << idx_d);
          busy_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  assign Y    = y_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign Err  = err_q;

endmodule

// File: tb/tb_ttl_decoder_seq.sv
// tb/tb_ttl_decoder_seq.sv - directed self-checking bench for ttl_decoder_seq (8-out and 6-out instances)
module tb_ttl_decoder_seq;

  logic       clk = 1'b0;
  logic       clear_bar;
  logic       e1b, e2b, e3_8, e3_6;
  logic [2:0] a;
  logic       stb_8, scan_8, stb_6, scan_6;
  logic [7:0] y_8;
  logic [5:0] y_6;
  logic       busy_8, done_8, err_8, busy_6, done_6, err_6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ttl_decoder_seq #(.WIDTH_OUT(8), .PULSE_LEN(3), .SCAN_DIV(2)) dut8 (
    .Clk(clk), .Clear_bar(clear_bar), .Enable1_bar(e1b), .Enable2_bar(e2b),
    .Enable3(e3_8), .A(a), .Strobe(stb_8), .Scan(scan_8),
    .Y(y_8), .Busy(busy_8), .Done(done_8), .Err(err_8)
  );

  ttl_decoder_seq #(.WIDTH_OUT(6), .PULSE_LEN(4), .SCAN_DIV(1)) dut6 (
    .Clk(clk), .Clear_bar(clear_bar), .Enable1_bar(e1b), .Enable2_bar(e2b),
    .Enable3(e3_6), .A(a), .Strobe(stb_6), .Scan(scan_6),
    .Y(y_6), .Busy(busy_6), .Done(done_6), .Err(err_6)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    clear_bar = 1'b0;
    e1b = 1'b0; e2b = 1'b0; e3_8 = 1'b1; e3_6 = 1'b1;
    a = 3'd0; stb_8 = 1'b0; scan_8 = 1'b0; stb_6 = 1'b0; scan_6 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_y8", y_8, 8'hFF);
    check("rst_y6", y_6, 6'h3F);
    check("rst_busy", busy_8, 1'b0);
    check("rst_done", done_8, 1'b0);
    check("rst_err", err_6, 1'b0);

    // one-shot A=5, strobe accepted on first edge after reset release
    clear_bar = 1'b1; a = 3'd5; stb_8 = 1'b1;
    step(); check("os5_y", y_8, 8'hDF); check("os5_busy", busy_8, 1'b1);
    a = 3'd2;
    step(); check("os5_y1", y_8, 8'hDF);
    step(); check("os5_y2", y_8, 8'hDF); check("os5_done_early", done_8, 1'b0);
    step(); check("os5_end_y", y_8, 8'hFF); check("os5_done", done_8, 1'b1);
    check("os5_end_busy", busy_8, 1'b0);
    step(); check("os2_y", y_8, 8'hFB); check("os2_done_clr", done_8, 1'b0);
    stb_8 = 1'b0;
    step(); check("os2_y1", y_8, 8'hFB);
    step(); check("os2_y2", y_8, 8'hFB);
    step(); check("os2_done", done_8, 1'b1); check("os2_end_y", y_8, 8'hFF);
    step(); check("os2_done_once", done_8, 1'b0);

    // out-of-range on 6-output instance
    a = 3'd7; stb_6 = 1'b1;
    step(); check("err_pulse", err_6, 1'b1); check("err_y", y_6, 6'h3F);
    check("err_busy", busy_6, 1'b0);
    stb_6 = 1'b0;
    step(); check("err_once", err_6, 1'b0);
    a = 3'd6; stb_6 = 1'b1;
    step(); check("err6_pulse", err_6, 1'b1); check("err6_y", y_6, 6'h3F);
    stb_6 = 1'b0;

    // Enable3 dropped in cycle 2 of a 4-cycle pulse
    a = 3'd3; stb_6 = 1'b1;
    step(); check("en_y", y_6, 6'h37); check("en_busy", busy_6, 1'b1);
    stb_6 = 1'b0; a = 3'd0;
    step(); check("en_y1", y_6, 6'h37);
    e3_6 = 1'b0;
    step(); check("en_drop_y", y_6, 6'h3F); check("en_drop_busy", busy_6, 1'b0);
    check("en_drop_done", done_6, 1'b0);
    step(); check("en_drop_nodone", done_6, 1'b0);
    a = 3'd1; stb_6 = 1'b1;
    step(); check("dis_y", y_6, 6'h3F); check("dis_busy", busy_6, 1'b0);
    stb_6 = 1'b0; e3_6 = 1'b1;

    // reset mid-ACTIVE, then strobe on first edge after release
    a = 3'd1; stb_8 = 1'b1;
    step(); check("ra_y", y_8, 8'hFD);
    a = 3'd4; clear_bar = 1'b0;
    #1; check("ra_async_y", y_8, 8'hFF); check("ra_async_busy", busy_8, 1'b0);
    @(negedge clk);
    clear_bar = 1'b1;
    step(); check("ra_first_y", y_8, 8'hEF); check("ra_first_done", done_8, 1'b0);
    stb_8 = 1'b0;
    step(); step();
    step(); check("ra_done", done_8, 1'b1);
    step();

`ifdef TTL_DECODER_SEQ_SCAN_EN
    scan_8 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      e = ~(8'h01 << ((i / 2) % 8));
      check($sformatf("scan_%0d", i), y_8, e);
    end
    scan_8 = 1'b0;
    step(); check("scan_off_y", y_8, 8'hFF); check("scan_off_busy", busy_8, 1'b0);

    scan_8 = 1'b1;
    step(); step(); step(); check("rs_y", y_8, 8'hFD);
    clear_bar = 1'b0;
    #1; check("rs_async_y", y_8, 8'hFF); check("rs_async_busy", busy_8, 1'b0);
    @(negedge clk);
    clear_bar = 1'b1; scan_8 = 1'b0;
    step(); check("rs_after_y", y_8, 8'hFF);

    a = 3'd6; stb_8 = 1'b1; scan_8 = 1'b1;
    step(); check("pri_y", y_8, 8'hBF); check("pri_busy", busy_8, 1'b1);
    stb_8 = 1'b0;
    step(); check("pri_y1", y_8, 8'hBF);
    step(); check("pri_y2", y_8, 8'hBF);
    step(); check("pri_done", done_8, 1'b1); check("pri_idle_y", y_8, 8'hFF);
    step(); check("pri_scan_y", y_8, 8'hFE); check("pri_scan_busy", busy_8, 1'b1);
    scan_8 = 1'b0;
    step(); check("pri_off_y", y_8, 8'hFF);
`else
    scan_8 = 1'b1;
    step(); check("noscan_y", y_8, 8'hFF); check("noscan_busy", busy_8, 1'b0);
    step(); check("noscan_y1", y_8, 8'hFF);
    scan_8 = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ttl_decoder_seq.md
TTL_DECODER_SEQ -- requirements
Module: ttl_decoder_seq

Interface
REQ-001 Parameter WIDTH_OUT, default 8: number of active-LOW select outputs, 2 to 64.
REQ-002 Parameter WIDTH_IN, default $clog2(WIDTH_OUT): address width.
REQ-003 Parameter PULSE_LEN, default 1: cycles a strobed output is held LOW, 1 to 255.
REQ-004 Parameter SCAN_DIV, default 4: cycles per scan step, 1 to 65535.
REQ-005 Clk  in  1  single clock, rising edge.
REQ-006 Clear_bar  in  1  reset, asynchronous, active-low.
REQ-007 Enable1_bar, Enable2_bar  in  1 each  active-low enables.
REQ-008 Enable3  in  1  active-high enable; all three enables active = "EN".
REQ-009 A  in  WIDTH_IN  address, sampled on an accepted Strobe.
REQ-010 Strobe  in  1  request a one-shot select pulse.
REQ-011 Scan  in  1  level request for continuous scan mode.
REQ-012 Y  out  WIDTH_OUT  registered select lines, at most one LOW.
REQ-013 Busy  out  1  high while in ACTIVE or SCAN.
REQ-014 Done  out  1  one-cycle pulse when a one-shot completes normally.
REQ-015 Err  out  1  one-cycle pulse when an out-of-range A is rejected.

Function
REQ-016 The FSM SHALL have states IDLE, ACTIVE and SCAN; all outputs are registered.
REQ-017 In IDLE, if EN and Strobe are sampled at edge k with A < WIDTH_OUT, the block SHALL latch A and go to ACTIVE; Y[A]=0 and Busy=1 from edge k.
REQ-018 ACTIVE SHALL last exactly PULSE_LEN cycles, counted by an 8-bit counter; at edge k+PULSE_LEN: Y all 1, Busy=0, Done=1 for one cycle, back to IDLE.
REQ-019 Strobe SHALL be accepted only in IDLE; Strobe in ACTIVE or SCAN is ignored, with no queuing. Back-to-back one-shots therefore have at least one IDLE cycle between them.
REQ-020 Changes on A during ACTIVE SHALL NOT affect Y.
REQ-021 If EN drops during ACTIVE, the block SHALL return to IDLE at the next edge with Y all 1, Busy=0 and no Done.
REQ-022 Strobe with EN and A >= WIDTH_OUT (WIDTH_OUT not a power of 2) SHALL pulse Err for one cycle, leave Y all 1, and stay in IDLE.
REQ-023 In IDLE, EN and Scan SHALL enter SCAN with index 0; Y[index]=0 from that edge.
REQ-024 In SCAN, the index SHALL advance every SCAN_DIV cycles and wrap from WIDTH_OUT-1 to 0.
REQ-025 Leaving SCAN SHALL occur at the next edge after Scan=0 or EN is lost; Y goes all 1, Busy=0, and the index clears.
REQ-026 Strobe and Scan sampled together in IDLE SHALL give Strobe priority.
REQ-027 Y SHALL never show more than one LOW bit in any cycle, including on state transitions.

Reset
REQ-028 Clear_bar low SHALL force, asynchronously: state IDLE, Y all 1, Busy=0, Done=0, Err=0, all counters and the latched A cleared.
REQ-029 Reset mid-ACTIVE or mid-SCAN SHALL abort without Done; the first Strobe is accepted on the first edge after Clear_bar deasserts.

Configuration
REQ-030 Macro TTL_DECODER_SEQ_SCAN_EN SHALL compile in the SCAN state, the SCAN_DIV divider and the scan index.
REQ-031 Without TTL_DECODER_SEQ_SCAN_EN, the Scan port SHALL remain present but ignored, and the FSM SHALL have only IDLE and ACTIVE.

Structure
REQ-032 Package ttl_decoder_seq_pkg SHALL hold the state enum typedef and the encodings IDLE=0, ACTIVE=1, SCAN=2.
REQ-033 The SCAN_DIV prescaler SHALL be a sub-module ttl_decoder_seq_div (terminal-count tick output, synchronous clear input).
REQ-034 No other sub-modules SHALL be used.

Verification
REQ-035 WIDTH_OUT=8, PULSE_LEN=3, Strobe with A=5 -> Y=8'hDF for 3 cycles, then Done pulses and Y=8'hFF.
REQ-036 During the REQ-035 pulse, Strobe with A=2 -> ignored, Y stays 8'hDF; A=2 is only taken after one IDLE cycle.
REQ-037 WIDTH_OUT=6, Strobe with A=7 -> Err pulses once, Y=6'h3F, no Busy.
REQ-038 SCAN_EN defined, SCAN_DIV=2, Scan=1 -> Y walks FE, FD, ..., 7F, FE, changing every 2 cycles; Scan=0 -> FF at the next edge.
REQ-039 Enable3 dropped in cycle 2 of PULSE_LEN=4 -> Y=FF at the next edge, no Done; Clear_bar low mid-SCAN -> immediate FF, Busy=0.
REQ-040 Strobe and Scan together in IDLE -> one-shot runs first; SCAN is entered only after Done and one IDLE cycle.
